bram_fifo_ctrl: RTL and testbench
=================================

// Module: bram_fifo_ctrl
// PURPOSE
//  Single-clock FIFO controller acting as the client of a 2K x 9 dual-port block RAM (8 data + 1 parity).
//  - Drives the RAM's port A as the write port and port B as the read port.
//  - Presents valid/ready streams on both sides, with first-word-fall-through output via a 2-stage read pipeline.
//  - Sits between byte-stream producers and consumers; the RAM primitive is instantiated alongside, by the parent.
// PARAMETERS
//  AW       11   RAM address width; DEPTH = 2**AW entries
//  DW        9   word width = {parity, data[7:0]}; fixed to match the RAM's 8+1 port
// PORTS
//  CLK       in   1     single clock; all logic on posedge
//  RST       in   1     asynchronous, active-high reset
//  FLUSH     in   1     synchronous clear of pointers, count and pipeline valids
//  S_DATA    in   9     write word {DIP, DI[7:0]}
//  S_VALID   in   1     write request
//  S_READY   out  1     write accept; =~full, registered
//  M_DATA    out  9     read word {DOP, DO[7:0]}
//  M_VALID   out  1     output word valid
//  M_READY   in   1     consumer accept
//  COUNT     out  AW+1  total words held (RAM + pipeline), 0..DEPTH+2
//  ADDRA/DIA/DIPA/ENA/WEA  out  AW/8/1/1/1  RAM port A (write); SSRA out, tied 0
//  ADDRB/ENB               out  AW/1        RAM port B (read); WEB, SSRB out, tied 0
//  DOB/DOPB                in   8/1         RAM port B read data, valid 1 cycle after ENB
// BEHAVIOUR
//  Reset (RST=1, async): S_READY=0 while RST is high and 1 on the first edge after release.
//   - M_VALID=0, M_DATA=0, COUNT=0, ENA=WEA=ENB=0.
//   - wr_ptr=rd_ptr=0 (AW+1 bits, MSB = wrap bit); dob_vld=0.
//   - RAM contents are not cleared.
//  Write: push = S_VALID & S_READY.
//   - ENA=WEA=push, ADDRA=wr_ptr[AW-1:0], DIA/DIPA=S_DATA, all combinational.
//   - wr_ptr += 1 on push.
//  RAM occupancy: ram_cnt = wr_ptr - rd_ptr (mod 2**(AW+1)).
//   - full = (ram_cnt == DEPTH); S_READY is a register, = ~full of next state.
//  Read pipeline: stage1 is the DOB/DOPB word (dob_vld); stage2 is the M_DATA register (M_VALID).
//   - adv  = dob_vld & (~M_VALID | M_READY)   (stage1 -> stage2)
//   - pop  = M_VALID & M_READY
//   - fetch = (ram_cnt != 0) & (~dob_vld | adv)
//   - ENB = fetch, ADDRB = rd_ptr[AW-1:0]; rd_ptr += 1 on fetch; dob_vld <= fetch | (dob_vld & ~adv).
//   - ENB=0 holds DOB, so stage1 holds under backpressure without an extra register.
//   - On adv, M_DATA <= {DOPB, DOB}; M_VALID <= adv | (M_VALID & ~pop).
//  Latency: write into an empty FIFO -> M_VALID high 3 edges later (push, fetch, adv).
//   - Sustained throughput is 1 word/clk each side.
//  Simultaneous push and fetch: no hazard.
//   - Fetch requires ram_cnt>0 before the edge, so a word is read at least 1 cycle after its write.
//   - Push never targets the address under fetch.
//  Full: push blocked; pop/fetch on the same edge frees space, and S_READY rises on the next edge.
//  Wrap: pointers wrap mod 2**(AW+1); full/empty are decided by the wrap bit.
//  COUNT = ram_cnt + dob_vld + M_VALID, registered, updated every edge; max DEPTH+2.
//  FLUSH: has priority over push/pop in the same cycle.
//   - Clears ptrs, dob_vld, M_VALID and COUNT; S_READY=1 next edge.
//  Reset mid-operation: all state is cleared immediately; in-flight RAM reads are discarded.
// STRUCTURE
//  Shared package bram_fifo_pkg holds:
//   - localparam RAM_AW=11, RAM_DW=9, RAM_DEPTH=2048
//   - typedef word_t = logic[8:0]
//   - typedef ptr_t = logic[RAM_AW:0]
//  One sub-module, fifo_ptr_gen: a pointer register with increment, wrap bit and sync clear.
//   - Instanced twice, once for wr_ptr and once for rd_ptr.
//  Read-pipeline control, COUNT and S_READY stay in the top.
//  The RAM is not instanced here.
// TESTING (bench wraps the block with a behavioural 2K x 9 RAM, read latency 1)
//  1 Reset release, push 0x0A5 with M_READY=1 -> M_VALID rises 3 edges after push, M_DATA=0x0A5, COUNT 1->0.
//  2 Hold M_READY=0, push 2050 words 0..2049 (mod 512) -> S_READY=0 after word 2050, COUNT=2050.
//    Then drain -> data is in order, with no duplicates or loss.
//  3 Full FIFO, single pop -> S_READY=1 on the next edge; push 0x1FF accepted.
//    The drained stream ends ...,0x1FF.
//  4 Random S_VALID/M_READY (50%), 10k words crossing pointer wrap twice.
//    -> The output matches a scoreboard and parity bit 8 is preserved.
//  5 FLUSH asserted together with S_VALID and M_READY at COUNT=7 -> next edge COUNT=0, M_VALID=0, no push.
//  6 Assert RST mid-burst (COUNT=100) -> outputs cleared asynchronously.
//    After release, a push of 0x055 emerges as the first word.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared sizing and types for the block-RAM FIFO controller.
package bram_fifo_pkg;
  localparam int RAM_AW    = 11;
  localparam int RAM_DW    = 9;
  localparam int RAM_DEPTH = 2048;

  typedef logic [RAM_DW-1:0] word_t;
  typedef logic [RAM_AW:0]   ptr_t;
endpackage

// File: rtl/bram_fifo_ctrl_ptr_gen.sv
// Pointer register with increment, extra wrap bit and synchronous clear.
// o_ptr_nxt exposes the next-state value so the parent can derive registered flags from it.
module fifo_ptr_gen #(
  parameter int AW = 11
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_inc,
  output logic [AW:0] o_ptr,
  output logic [AW:0] o_ptr_nxt
);
  logic [AW:0] r_ptr;

  always_comb begin
    o_ptr_nxt = r_ptr;
    if (i_clr)
      o_ptr_nxt = '0;
    else if (i_inc)
      o_ptr_nxt = r_ptr + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_ptr <= '0;
    else
      r_ptr <= o_ptr_nxt;
  end

  assign o_ptr = r_ptr;
endmodule

// File: rtl/bram_fifo_ctrl.sv
// FIFO controller for an external 2K x 9 dual-port block RAM: port A writes, port B reads,
// with a two-stage first-word-fall-through read pipeline (RAM output register, then M_DATA).
module bram_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FLUSH,
  input  logic [DW-1:0] S_DATA,
  input  logic          S_VALID,
  output logic          S_READY,
  output logic [DW-1:0] M_DATA,
  output logic          M_VALID,
  input  logic          M_READY,
  output logic [AW:0]   COUNT,
  output logic [AW-1:0] ADDRA,
  output logic [7:0]    DIA,
  output logic          DIPA,
  output logic          ENA,
  output logic          WEA,
  output logic          SSRA,
  output logic [AW-1:0] ADDRB,
  output logic          ENB,
  output logic          WEB,
  output logic          SSRB,
  input  logic [7:0]    DOB,
  input  logic          DOPB
);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  logic [AW:0]   w_wr_ptr, w_wr_nxt, w_rd_ptr, w_rd_nxt;
  logic [AW:0]   w_ram_cnt, w_ram_cnt_nxt, w_count_nxt;
  logic          w_push, w_pop, w_adv, w_fetch;
  logic          w_dob_vld_nxt, w_m_valid_nxt;
  logic          r_s_ready, r_dob_vld, r_m_valid;
  logic [DW-1:0] r_m_data;
  logic [AW:0]   r_count;

  fifo_ptr_gen #(.AW(AW)) u_wr_ptr (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_clr     (FLUSH),
    .i_inc     (w_push),
    .o_ptr     (w_wr_ptr),
    .o_ptr_nxt (w_wr_nxt)
  );

  fifo_ptr_gen #(.AW(AW)) u_rd_ptr (
    .i_clk     (CLK),
    .i_rst     (RST),
    .i_clr     (FLUSH),
    .i_inc     (w_fetch),
    .o_ptr     (w_rd_ptr),
    .o_ptr_nxt (w_rd_nxt)
  );

  // FLUSH wins over every transfer, so push and fetch are masked by it.
  assign w_push    = S_VALID & r_s_ready & ~FLUSH;
  assign w_pop     = r_m_valid & M_READY;
  assign w_adv     = r_dob_vld & (~r_m_valid | M_READY);
  assign w_ram_cnt = w_wr_ptr - w_rd_ptr;
  assign w_fetch   = (w_ram_cnt != '0) & (~r_dob_vld | w_adv) & ~FLUSH;

  assign w_dob_vld_nxt = ~FLUSH & (w_fetch | (r_dob_vld & ~w_adv));
  assign w_m_valid_nxt = ~FLUSH & (w_adv | (r_m_valid & ~w_pop));
  assign w_ram_cnt_nxt = w_wr_nxt - w_rd_nxt;
  assign w_count_nxt   = w_ram_cnt_nxt + {{AW{1'b0}}, w_dob_vld_nxt}
                                       + {{AW{1'b0}}, w_m_valid_nxt};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_s_ready <= 1'b0;
      r_dob_vld <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
      r_count   <= '0;
    end else begin
      r_s_ready <= (w_ram_cnt_nxt != DEPTH);
      r_dob_vld <= w_dob_vld_nxt;
      r_m_valid <= w_m_valid_nxt;
      r_count   <= w_count_nxt;
      // With ENB low the RAM holds DOB, so stage 1 needs no register of its own.
      if (w_adv)
        r_m_data <= {DOPB, DOB};
    end
  end

  assign S_READY = r_s_ready;
  assign M_VALID = r_m_valid;
  assign M_DATA  = r_m_data;
  assign COUNT   = r_count;

  assign ADDRA = w_wr_ptr[AW-1:0];
  assign DIA   = S_DATA[7:0];
  assign DIPA  = S_DATA[8];
  assign ENA   = w_push;
  assign WEA   = w_push;
  assign SSRA  = 1'b0;

  assign ADDRB = w_rd_ptr[AW-1:0];
  assign ENB   = w_fetch;
  assign WEB   = 1'b0;
  assign SSRB  = 1'b0;
endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Bench for bram_fifo_ctrl with a behavioural 2K x 9 RAM (read latency 1) and a queue scoreboard.
module tb_bram_fifo_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        FLUSH = 1'b0;
  logic [8:0]  S_DATA = '0;
  logic        S_VALID = 1'b0;
  logic        S_READY;
  logic [8:0]  M_DATA;
  logic        M_VALID;
  logic        M_READY = 1'b0;
  logic [11:0] COUNT;
  logic [10:0] ADDRA, ADDRB;
  logic [7:0]  DIA, DOB;
  logic        DIPA, ENA, WEA, SSRA, ENB, WEB, SSRB, DOPB;

  logic [8:0] mem [0:2047];

  bram_fifo_ctrl dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .COUNT(COUNT),
    .ADDRA(ADDRA), .DIA(DIA), .DIPA(DIPA), .ENA(ENA), .WEA(WEA), .SSRA(SSRA),
    .ADDRB(ADDRB), .ENB(ENB), .WEB(WEB), .SSRB(SSRB),
    .DOB(DOB), .DOPB(DOPB)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ENA && WEA) mem[ADDRA] <= {DIPA, DIA};
    if (ENB) {DOPB, DOB} <= mem[ADDRB];
  end

  int checks = 0;
  int failures = 0;
  int n_push = 0;
  int n_pop = 0;
  logic [8:0] last_pop = '0;
  logic [8:0] sb [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Records the transfers the current inputs imply, then advances one edge.
  task automatic tick();
    logic [8:0] e;
    if (!RST) begin
      if (FLUSH) begin
        sb.delete();
      end else begin
        if (M_VALID && M_READY) begin
          n_pop++;
          last_pop = M_DATA;
          if (sb.size() == 0) begin
            chk("pop_unexpected", 32'(M_DATA), 32'h0);
            failures += (M_DATA == 9'h0) ? 1 : 0;
          end else begin
            e = sb.pop_front();
            chk("pop_data", 32'(M_DATA), 32'(e));
          end
        end
        if (S_VALID && S_READY) begin
          sb.push_back(S_DATA);
          n_push++;
        end
      end
    end
    @(posedge CLK);
    #1;
  endtask

  typedef struct {
    logic       sv;
    logic [8:0] sd;
    logic       mr;
    logic       fl;
    logic       e_rdy;
    logic       e_mv;
    logic [8:0] e_md;
    logic [11:0] e_cnt;
  } vec_t;

  vec_t vecs [13];

  initial begin
    int idx;
    int cyc;
    int pops0;
    int push0;

    vecs[0] = '{1'b1, 9'h0A5, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 12'd1};
    vecs[1] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 12'd1};
    vecs[2] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b1, 9'h0A5, 12'd1};
    vecs[3] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 12'd0};
    for (int k = 1; k <= 7; k++)
      vecs[3+k] = '{1'b1, 9'(9'h100 + k), 1'b0, 1'b0, 1'b1, (k >= 3), 9'h101, 12'(k)};
    vecs[11] = '{1'b1, 9'h1AA, 1'b1, 1'b1, 1'b1, 1'b0, 9'h000, 12'd0};
    vecs[12] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1, 1'b0, 9'h000, 12'd0};

    #1;
    chk("rst_s_ready", 32'(S_READY), 32'd0);
    chk("rst_m_valid", 32'(M_VALID), 32'd0);
    chk("rst_count",   32'(COUNT),   32'd0);
    chk("rst_enb",     32'(ENB),     32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    tick();
    chk("rel_s_ready", 32'(S_READY), 32'd1);

    // Single-word latency and the FLUSH-at-COUNT=7 case
    for (int i = 0; i < 13; i++) begin
      S_VALID = vecs[i].sv;
      S_DATA  = vecs[i].sd;
      M_READY = vecs[i].mr;
      FLUSH   = vecs[i].fl;
      tick();
      chk($sformatf("vec%0d_s_ready", i), 32'(S_READY), 32'(vecs[i].e_rdy));
      chk($sformatf("vec%0d_m_valid", i), 32'(M_VALID), 32'(vecs[i].e_mv));
      chk($sformatf("vec%0d_count", i),   32'(COUNT),   32'(vecs[i].e_cnt));
      if (vecs[i].e_mv)
        chk($sformatf("vec%0d_m_data", i), 32'(M_DATA), 32'(vecs[i].e_md));
    end
    FLUSH = 1'b0;
    S_VALID = 1'b0;

    // Fill to DEPTH+2 with the consumer stalled
    M_READY = 1'b0;
    idx = 0;
    cyc = 0;
    while (idx < 2050 && cyc < 3000) begin
      S_VALID = 1'b1;
      S_DATA  = 9'(idx);
      if (S_READY) idx++;
      tick();
      cyc++;
    end
    chk("fill_done", 32'(idx), 32'd2050);
    chk("full_s_ready", 32'(S_READY), 32'd0);
    chk("full_count", 32'(COUNT), 32'd2050);
    S_DATA = 9'h1FF;
    tick();
    chk("full_hold_count", 32'(COUNT), 32'd2050);
    chk("full_hold_rdy", 32'(S_READY), 32'd0);

    // One pop from full frees space on the next edge
    S_VALID = 1'b0;
    M_READY = 1'b1;
    tick();
    M_READY = 1'b0;
    chk("pop1_s_ready", 32'(S_READY), 32'd1);
    chk("pop1_count", 32'(COUNT), 32'd2049);
    S_VALID = 1'b1;
    S_DATA  = 9'h1FF;
    tick();
    S_VALID = 1'b0;
    chk("refill_count", 32'(COUNT), 32'd2050);
    chk("refill_s_ready", 32'(S_READY), 32'd0);

    pops0 = n_pop;
    M_READY = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 2200) begin
      tick();
      cyc++;
    end
    chk("drain_words", 32'(n_pop - pops0), 32'd2050);
    chk("drain_last", 32'(last_pop), 32'h1FF);
    chk("drain_count", 32'(COUNT), 32'd0);
    chk("drain_m_valid", 32'(M_VALID), 32'd0);

    // Random traffic across pointer wrap
    push0 = n_push;
    cyc = 0;
    while ((n_push - push0 < 10000 || sb.size() != 0) && cyc < 60000) begin
      S_VALID = (n_push - push0 < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
      S_DATA  = 9'($urandom_range(0, 511));
      M_READY = 1'($urandom_range(0, 1));
      tick();
      cyc++;
    end
    S_VALID = 1'b0;
    chk("rand_pushed", 32'(n_push - push0), 32'd10000);
    chk("rand_sb_empty", 32'(sb.size()), 32'd0);
    tick();
    chk("rand_count", 32'(COUNT), 32'd0);

    // Async reset in the middle of a burst
    M_READY = 1'b0;
    cyc = 0;
    while (COUNT < 12'd100 && cyc < 300) begin
      S_VALID = 1'b1;
      S_DATA  = 9'(cyc);
      tick();
      cyc++;
    end
    chk("burst_count", 32'(COUNT), 32'd100);
    #2;
    RST = 1'b1;
    #1;
    chk("arst_m_valid", 32'(M_VALID), 32'd0);
    chk("arst_count",   32'(COUNT),   32'd0);
    chk("arst_s_ready", 32'(S_READY), 32'd0);
    chk("arst_ena",     32'(ENA),     32'd0);
    chk("arst_enb",     32'(ENB),     32'd0);
    sb.delete();
    @(posedge CLK);
    #1;
    chk("arst_hold_rdy", 32'(S_READY), 32'd0);
    RST = 1'b0;
    S_VALID = 1'b0;
    tick();
    chk("arst_rel_rdy", 32'(S_READY), 32'd1);
    chk("arst_rel_count", 32'(COUNT), 32'd0);
    pops0 = n_pop;
    S_VALID = 1'b1;
    S_DATA  = 9'h055;
    M_READY = 1'b1;
    tick();
    S_VALID = 1'b0;
    cyc = 0;
    while (n_pop == pops0 && cyc < 10) begin
      tick();
      cyc++;
    end
    chk("arst_first_pops", 32'(n_pop - pops0), 32'd1);
    chk("arst_first_word", 32'(last_pop), 32'h055);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
